// File: rtl/bp_pkg.sv
// Shared types and encodings for the fetch-stage branch predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_pkg;

    // 2-bit saturating direction counter; the MSB is the taken prediction.
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;  // strong not-taken
    localparam ctr_t CTR_WNT = 2'b01;  // weak not-taken
    localparam ctr_t CTR_WT  = 2'b10;  // weak taken
    localparam ctr_t CTR_ST  = 2'b11;  // strong taken

    // Empty entries start weak-NT so that a first taken outcome needs no history.
    localparam ctr_t CTR_INIT  = CTR_WNT;
    // A freshly allocated entry predicts taken, but one not-taken flips it.
    localparam ctr_t CTR_ALLOC = CTR_WT;

endpackage : bp_pkg

// File: rtl/bp_sat_ctr.sv
// Next-value function of a 2-bit saturating direction counter.
// Latency: combinational, 0 cycles.
// Backpressure: none; a pure function of its inputs.
//
// Ports:
//   ctr      current counter value
//   taken    resolved branch outcome
//   ctr_next counter value after training with the outcome
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule : bp_sat_ctr

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor: fetch lookup, EX training, mispredict/redirect.
// Latency: lookup and mispredict are combinational; a table write is visible the cycle after the update edge.
// Backpressure: none; the pipeline keeps upd_valid_i low while EX is stalled or flushed.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   pc_f_i                 fetch PC to look up
//   pred_taken_o           predicted taken for pc_f_i
//   pred_target_o          predicted next PC for pc_f_i
//   upd_valid_i            EX holds a valid conditional branch this cycle
//   upd_pc_i               PC of the resolving branch
//   upd_taken_i            resolved outcome
//   upd_target_i           computed branch target
//   upd_pred_taken_i       prediction made at fetch, carried down the pipe
//   upd_pred_target_i      predicted next PC, carried down the pipe
//   mispredict_o           flush IF/ID and redirect fetch
//   redirect_pc_o          correct next PC, meaningful only with mispredict_o
//   br_cnt_o, miss_cnt_o   wrapping 16-bit resolved-branch / mispredict counts
module branch_predictor
    import bp_pkg::*;
#(
    parameter int n       = 32,
    parameter int ENTRIES = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [n-1:0] pc_f_i,
    output logic         pred_taken_o,
    output logic [n-1:0] pred_target_o,
    input  logic         upd_valid_i,
    input  logic [n-1:0] upd_pc_i,
    input  logic         upd_taken_i,
    input  logic [n-1:0] upd_target_i,
    input  logic         upd_pred_taken_i,
    input  logic [n-1:0] upd_pred_target_i,
    output logic         mispredict_o,
    output logic [n-1:0] redirect_pc_o,
    output logic [15:0]  br_cnt_o,
    output logic [15:0]  miss_cnt_o
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = n - IDX - 2;
    localparam logic [n-1:0] PC_STEP = n'(4);

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [n-1:0]    target;
        ctr_t            ctr;
    } entry_t;

    localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};

    // Kept as a flop array: the fetch lookup is asynchronous, so this cannot be an SRAM.
    entry_t table_q [ENTRIES];

    logic [15:0] br_cnt_q;
    logic [15:0] miss_cnt_q;

    // ---------------- fetch lookup ----------------
    logic [IDX-1:0]  f_idx;
    logic [TAGW-1:0] f_tag;
    entry_t          f_ent;
    logic            f_hit;

    assign f_idx = pc_f_i[IDX+1:2];
    assign f_tag = pc_f_i[n-1:IDX+2];
    assign f_ent = table_q[f_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

    // Reads the registered table only, so a same-cycle update is not bypassed.
    assign pred_taken_o  = f_hit && f_ent.ctr[1];
    assign pred_target_o = pred_taken_o ? f_ent.target : pc_f_i + PC_STEP;

    // ---------------- EX resolution ----------------
    logic [IDX-1:0]  u_idx;
    logic [TAGW-1:0] u_tag;
    entry_t          u_ent;
    logic            u_hit;
    ctr_t            u_ctr_next;

    assign u_idx = upd_pc_i[IDX+1:2];
    assign u_tag = upd_pc_i[n-1:IDX+2];
    assign u_ent = table_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr      (u_ent.ctr),
        .taken    (upd_taken_i),
        .ctr_next (u_ctr_next)
    );

    // A taken branch is also mispredicted when it went to the wrong place.
    assign mispredict_o  = upd_valid_i &&
                           ((upd_taken_i != upd_pred_taken_i) ||
                            (upd_taken_i && (upd_target_i != upd_pred_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PC_STEP;

    // ---------------- table and statistics state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= ENTRY_RST;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd_valid_i) begin
                if (u_hit) begin
                    table_q[u_idx].ctr <= u_ctr_next;
                    if (upd_taken_i) begin
                        table_q[u_idx].target <= upd_target_i;
                    end
                end else if (upd_taken_i) begin
                    // Allocation evicts whatever aliased into this slot.
                    table_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target_i, ctr: CTR_ALLOC};
                end
                br_cnt_q <= br_cnt_q + 16'd1;
            end
            if (mispredict_o) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign br_cnt_o   = br_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: per-cycle vector table through a scoreboard queue,
// followed by hand-written sequences for asynchronous reset and counter wrap.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.n(32), .ENTRIES(16)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pc_f_i            (pc_f),
        .pred_taken_o      (pred_taken),
        .pred_target_o     (pred_target),
        .upd_valid_i       (upd_valid),
        .upd_pc_i          (upd_pc),
        .upd_taken_i       (upd_taken),
        .upd_target_i      (upd_target),
        .upd_pred_taken_i  (upd_pred_taken),
        .upd_pred_target_i (upd_pred_target),
        .mispredict_o      (mispredict),
        .redirect_pc_o     (redirect_pc),
        .br_cnt_o          (br_cnt),
        .miss_cnt_o        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected before the following rising edge.
    typedef struct {
        logic [31:0] pc_f;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_misp;
        logic [31:0] e_redir;
        logic [15:0] e_br;
        logic [15:0] e_miss;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [31:0] pcf, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic upt,
                                input logic [31:0] uptgt, input logic ept, input logic [31:0] eptgt,
                                input logic emisp, input logic [31:0] eredir,
                                input logic [15:0] ebr, input logic [15:0] emiss);
        vec_t v;
        v.pc_f = pcf; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.e_pt = ept; v.e_ptgt = eptgt;
        v.e_misp = emisp; v.e_redir = eredir; v.e_br = ebr; v.e_miss = emiss;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_f            = v.pc_f;
        upd_valid       = v.uv;
        upd_pc          = v.upc;
        upd_taken       = v.ut;
        upd_target      = v.utgt;
        upd_pred_taken  = v.upt;
        upd_pred_target = v.uptgt;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        // pc_f, uv, upc, ut, utgt, upt, uptgt | pred_taken, pred_target, mispredict, redirect, br, miss
        vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0,   0, 0));
        vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200, 0, 0));
        vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h0,   1, 1));
        vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h0,   2, 1));
        vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, 1, 32'h200, 1, 32'h104, 3, 1));
        vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, 1, 32'h200, 1, 32'h104, 4, 2));
        vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0,   5, 3));
        vecs.push_back(mk(32'h140, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h144, 1, 32'h200, 5, 3));
        vecs.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0, 32'h144, 1, 32'h300, 6, 4));
        vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0,   7, 5));
        vecs.push_back(mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0,   7, 5));
        vecs.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 1, 32'h300, 1, 32'h300, 0, 32'h0,   7, 5));
        vecs.push_back(mk(32'h140, 1, 32'h140, 1, 32'h380, 1, 32'h300, 1, 32'h300, 1, 32'h380, 8, 5));
        vecs.push_back(mk(32'h140, 1, 32'h500, 0, 32'h0,   0, 32'h504, 1, 32'h380, 0, 32'h0,   9, 6));
        vecs.push_back(mk(32'h500, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h504, 0, 32'h0,  10, 6));
        vecs.push_back(mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 0, 32'h0, 1, 32'h0, 10, 6));
        vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 11, 7));
        vecs.push_back(mk(32'h140, 0, 32'h140, 1, 32'h900, 0, 32'h144, 1, 32'h380, 0, 32'h0,  11, 7));
        vecs.push_back(mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h0,  11, 7));

        rst_n = 1'b0;
        drive(mk(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven phase: drive at the falling edge, check 2 ns later, well before the rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            drive(v);
            exp_q.push_back(v);
            #2;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard[%0d]: got empty queue expected entry", i);
            end else begin
                e = exp_q.pop_front();
                check("pred_taken",  i, {31'b0, pred_taken}, {31'b0, e.e_pt});
                check("pred_target", i, pred_target, e.e_ptgt);
                check("mispredict",  i, {31'b0, mispredict}, {31'b0, e.e_misp});
                if (e.e_misp) check("redirect_pc", i, redirect_pc, e.e_redir);
                check("br_cnt",   i, {16'b0, br_cnt},   {16'b0, e.e_br});
                check("miss_cnt", i, {16'b0, miss_cnt}, {16'b0, e.e_miss});
            end
        end

        // Asynchronous reset with no clock edge: the entry at 0x140 is live (0x380) beforehand.
        @(negedge clk);
        drive(mk(32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0));
        #1;
        check("pre_reset_pt", 100, {31'b0, pred_taken}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pt",   101, {31'b0, pred_taken}, 32'h0);
        check("async_rst_ptgt", 101, pred_target, 32'h144);
        check("async_rst_br",   101, {16'b0, br_cnt},   32'h0);
        check("async_rst_miss", 101, {16'b0, miss_cnt}, 32'h0);

        // An update presented while reset is held must be discarded.
        drive(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h0, 0, 32'h0, 0, 0));
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_upd_pt",   102, {31'b0, pred_taken}, 32'h0);
        check("rst_upd_ptgt", 102, pred_target, 32'h104);
        check("rst_upd_br",   102, {16'b0, br_cnt}, 32'h0);

        // Counter wrap: 65535 correctly predicted not-taken branches, then one mispredict.
        drive(mk(32'h800, 0, 32'h800, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0));
        for (int k = 0; k < 65535; k++) begin
            @(negedge clk);
            upd_valid = 1'b1;
        end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        check("br_cnt_max",   103, {16'b0, br_cnt},   32'hFFFF);
        check("miss_cnt_max", 103, {16'b0, miss_cnt}, 32'h0);
        upd_valid      = 1'b1;
        upd_pred_taken = 1'b1;
        #1;
        check("wrap_misp",  104, {31'b0, mispredict}, 32'h1);
        check("wrap_redir", 104, redirect_pc, 32'h804);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        check("br_cnt_wrap",   105, {16'b0, br_cnt},   32'h0);
        check("miss_cnt_wrap", 105, {16'b0, miss_cnt}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_predictor
